// File: rtl/debounce_pulse_tx.sv
// Fixed-width pulse transmitter: each request becomes HIGH_CYCLES of Q=1 then LOW_CYCLES of Q=0.
// Optional pending-request queue enabled by macro DEBOUNCE_PULSE_TX_QUEUE_EN.
module debounce_pulse_tx #(
    parameter int unsigned HIGH_CYCLES = 4,
    parameter int unsigned LOW_CYCLES  = 4,
    parameter int unsigned PEND_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              Q,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    localparam logic [7:0] HI_LOAD = 8'(HIGH_CYCLES - 1);
    localparam logic [7:0] LO_LOAD = 8'(LOW_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        q_q, q_d;
    logic        busy_q, busy_d;
    logic [7:0]  drop_q, drop_d;
    logic        low_end;
    logic        req_busy;
    logic        avail;

`ifdef DEBOUNCE_PULSE_TX_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    logic [PEND_W-1:0] pend_q, pend_d;
    assign avail = (pend_q != '0) || req;
`else
    assign avail = req;
`endif

    assign low_end  = (state_q == S_LOW) && (cnt_q == '0);
    assign req_busy = req && (state_q != S_IDLE) && !low_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        drop_d  = drop_q;
`ifdef DEBOUNCE_PULSE_TX_QUEUE_EN
        pend_d  = pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                q_d = 1'b0;
                if (req) begin
                    state_d = S_HIGH;
                    cnt_d   = HI_LOAD;
                    q_d     = 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = S_LOW;
                    cnt_d   = LO_LOAD;
                    q_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (avail) begin
                    state_d = S_HIGH;
                    cnt_d   = HI_LOAD;
                    q_d     = 1'b1;
`ifdef DEBOUNCE_PULSE_TX_QUEUE_EN
                    // Queued entry wins; a concurrent req takes its slot, so depth is unchanged.
                    if (pend_q != '0 && !req) begin
                        pend_d = pend_q - 1'b1;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                q_d     = 1'b0;
            end
        endcase

        if (req_busy) begin
`ifdef DEBOUNCE_PULSE_TX_QUEUE_EN
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + 1'b1;
            end else if (drop_q != '1) begin
                drop_d = drop_q + 8'd1;
            end
`else
            if (drop_q != '1) begin
                drop_d = drop_q + 8'd1;
            end
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

`ifdef DEBOUNCE_PULSE_TX_QUEUE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end
    assign pend_cnt = pend_q;
`else
    assign pend_cnt = '0;
`endif

    assign Q        = q_q;
    assign busy     = busy_q;
    assign drop_cnt = drop_q;

endmodule
